execute_muldiv: RTL and testbench

Parametrised execute stage for the MIPS pipeline. It sits between decode/issue and memory. Single-cycle ALU results pass through it. It adds a multi-cycle multiply/divide unit with architectural HI/LO registers, valid/ready handshakes on both sides, and a pipeline flush.

---
 rtl/execute_muldiv.sv | 232 +++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// execute_muldiv: MIPS execute stage. Single-cycle ALU results and HI/LO
// moves pass through a registered output slot. MULT/MULTU/DIV/DIVU occupy a
// multi-cycle unit that owns the architectural HI/LO registers.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds its payload stable while
// valid && !ready. Ready never depends on the valid of the same port.
module execute_muldiv #(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_alu,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wen,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Counter must reach WIDTH (divider fix-up cycle) and MUL_STAGES-1.
  localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state_q, state_nx;

  logic             accept;
  logic             in_is_mul, in_is_div, in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             mul_done, div_done;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] op_a_q;      // raw rs: multiplicand, or dividend for the /0 case
  logic [WIDTH-1:0] op_b_q;      // raw rt for multiply, |rt| for divide
  logic             sgn_q;       // signed multiply
  logic             a_neg_q, b_neg_q;
  logic             div_zero_q, div_ovf_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0]   sc_result;
  logic               sc_wen;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic [WIDTH-1:0]   rem_sh, rem_nx, quo_nx, q_fix, r_fix, div_lo, div_hi;
  logic               sub_ok;

  assign in_is_mul = (in_op == OP_MULT) || (in_op == OP_MULTU);
  assign in_is_div = (in_op == OP_DIV)  || (in_op == OP_DIVU);
  assign in_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
  assign abs_a     = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign abs_b     = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign accept    = in_valid && in_ready;
  assign mul_done  = (state_q == S_MUL) && (cnt_q == MUL_LAST);
  assign div_done  = (state_q == S_DIV) && (cnt_q == DIV_LAST);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && in_is_mul)      state_nx = S_MUL;
        else if (accept && in_is_div) state_nx = S_DIV;
      end
      S_MUL:   if (mul_done) state_nx = S_IDLE;
      S_DIV:   if (div_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // FSM outputs: accept only when idle and the output slot is free or draining.
  always_comb begin
    busy     = (state_q != S_IDLE);
    in_ready = (state_q == S_IDLE) && (!out_valid || out_ready) && !flush;
  end

  // Result and GPR write-enable for ops that complete in one cycle.
  always_comb begin
    sc_result = in_alu;
    sc_wen    = 1'b1;
    case (in_op)
      OP_MFHI: sc_result = hi_q;
      OP_MFLO: sc_result = lo_q;
      OP_MTHI, OP_MTLO: begin
        sc_result = in_a;
        sc_wen    = 1'b0;
      end
      default: ;
    endcase
  end

  // Full-width product; sign extension makes one multiplier serve both signs.
  assign mul_a_ext = {{WIDTH{sgn_q & op_a_q[WIDTH-1]}}, op_a_q};
  assign mul_b_ext = {{WIDTH{sgn_q & op_b_q[WIDTH-1]}}, op_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring-division step plus the final sign fix-up and special cases.
  // A set remainder MSB means the shifted value exceeds any WIDTH-bit divisor.
  always_comb begin
    rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    sub_ok = rem_q[WIDTH-1] || (rem_sh >= op_b_q);
    rem_nx = sub_ok ? (rem_sh - op_b_q) : rem_sh;
    quo_nx = {quo_q[WIDTH-2:0], sub_ok};
    q_fix  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    r_fix  = a_neg_q ? -rem_q : rem_q;
    div_lo = q_fix;
    div_hi = r_fix;
    if (div_zero_q) begin
      div_lo = '1;
      div_hi = op_a_q;
    end else if (div_ovf_q) begin
      div_lo = MOST_NEG;
      div_hi = '0;
    end
  end

  // Operand capture at acceptance, cycle counter and divider iterations.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sgn_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      tag_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
    end else if (accept) begin
      cnt_q      <= '0;
      op_a_q     <= in_a;
      op_b_q     <= in_is_div ? abs_b : in_b;
      sgn_q      <= in_signed;
      a_neg_q    <= in_signed && in_a[WIDTH-1];
      b_neg_q    <= in_signed && in_b[WIDTH-1];
      div_zero_q <= (in_b == '0);
      div_ovf_q  <= (in_op == OP_DIV) && (in_a == MOST_NEG) && (in_b == '1);
      tag_q      <= in_tag;
      quo_q      <= abs_a;
      rem_q      <= '0;
    end else if (state_q != S_IDLE) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if ((state_q == S_DIV) && (cnt_q < DIV_LAST)) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
      end
    end
  end

  // HI/LO: moves at acceptance, multiply/divide on their final cycle, never under flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush) begin
      if (accept && (in_op == OP_MTHI)) hi_q <= in_a;
      if (accept && (in_op == OP_MTLO)) lo_q <= in_a;
      if (mul_done) {hi_q, lo_q} <= product;
      if (div_done) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
    end
  end

  // Output slot: load on single-cycle acceptance or multi-cycle completion, clear on drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_wen    <= 1'b0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !in_is_mul && !in_is_div) begin
      out_valid  <= 1'b1;
      out_result <= sc_result;
      out_wen    <= sc_wen;
      out_tag    <= in_tag;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      out_result <= product[WIDTH-1:0];
      out_wen    <= 1'b0;
      out_tag    <= tag_q;
    end else if (div_done) begin
      out_valid  <= 1'b1;
      out_result <= div_lo;
      out_wen    <= 1'b0;
      out_tag    <= tag_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Testbench for execute_muldiv: directed vector table, hand-written
// multi-cycle sequences (hold, flush, reset) and randomized ops checked
// against an arithmetic reference model through a result scoreboard.
module tb_execute_muldiv;

  localparam int WIDTH      = 32;
  localparam int TAG_W      = 8;
  localparam int MUL_STAGES = 2;
  localparam int EXP_W      = 1 + TAG_W + WIDTH;

  localparam logic [3:0] OP_ALU   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic             clk = 1'b0;
  logic             resetn, flush, in_valid, in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b, in_alu, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_valid, out_ready, out_wen, busy;

  execute_muldiv #(.WIDTH(WIDTH), .TAG_W(TAG_W), .MUL_STAGES(MUL_STAGES)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_alu(in_alu), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wen(out_wen), .out_tag(out_tag), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready modes: 0 always ready, 1 stalled, 2 random
  int ready_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not reach its summary in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               out_cyc_q[$];
  logic [EXP_W-1:0] mon_exp;
  logic [WIDTH-1:0] m_hi = '0;
  logic [WIDTH-1:0] m_lo = '0;
  int               accept_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit and integer arithmetic.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] alu, output logic [31:0] res, output logic wen);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    res = alu;
    wen = 1'b1;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = sp;
        res = m_lo; wen = 1'b0;
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = up;
        res = m_lo; wen = 1'b0;
      end
      OP_DIV: begin
        if (b == 32'h0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_lo = 32'h80000000; m_hi = 32'h0;
        end else begin
          sa = a; sb = b;
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
        res = m_lo; wen = 1'b0;
      end
      OP_DIVU: begin
        if (b == 32'h0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        res = m_lo; wen = 1'b0;
      end
      OP_MFHI: res = m_hi;
      OP_MFLO: res = m_lo;
      OP_MTHI: begin m_hi = a; res = a; wen = 1'b0; end
      OP_MTLO: begin m_lo = a; res = a; wen = 1'b0; end
      default: ;
    endcase
  endtask

  // Every consumed result is matched against the next expected one.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h tag %h with nothing pending", out_result, out_tag);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", 64'({out_wen, out_tag, out_result}), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returns 1 time unit after a rising edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] alu, input logic [7:0] tag, input bit track);
    logic [31:0] res;
    logic        wen;
    bit          got;
    in_op = op; in_a = a; in_b = b; in_alu = alu; in_tag = tag; in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      in_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0d, required 1", op);
    end else begin
      accept_cyc = cyc;
      if (track) begin
        model_exec(op, a, b, alu, res, wen);
        exp_q.push_back({wen, tag, res});
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns at the falling edge where out_valid is first seen.
  task automatic wait_out(input int budget, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (got) lat = cyc - accept_cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL out_timeout: out_valid stayed 0 for %0d cycles, required 1", budget);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, alu;
    logic [31:0] exp_res;
    logic        exp_wen;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alu, input logic [31:0] res, input logic wen,
                         input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.alu = alu;
    v.exp_res = res; v.exp_wen = wen; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          lat;
    int          seen;
    logic [31:0] hold_val;
    logic [3:0]  rop;
    int          r;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_alu = '0; in_tag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_wen", 64'(out_wen), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, applied one at a time with latency measured
    add_vec(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'h0, 32'hFFFFFFF1, 1'b0, 3);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'hFFFFFFFF, 1'b1, 1);
    add_vec(OP_MFLO,  32'h0,        32'h0,        32'h0, 32'hFFFFFFF1, 1'b1, 1);
    add_vec(OP_DIVU,  32'd100,      32'd7,        32'h0, 32'd14,       1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'd2,        1'b1, 1);
    add_vec(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'hFFFFFFFD, 1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'hFFFFFFFF, 1'b1, 1);
    add_vec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'h0,        1'b1, 1);
    add_vec(OP_DIVU,  32'd5,        32'd0,        32'h0, 32'hFFFFFFFF, 1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'd5,        1'b1, 1);
    add_vec(OP_MTHI,  32'h12345678, 32'h0,        32'h0, 32'h12345678, 1'b0, 1);
    add_vec(OP_MTLO,  32'hCAFEF00D, 32'h0,        32'h0, 32'hCAFEF00D, 1'b0, 1);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'h12345678, 1'b1, 1);
    add_vec(OP_MFLO,  32'h0,        32'h0,        32'h0, 32'hCAFEF00D, 1'b1, 1);
    add_vec(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b0, 3);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'hFFFFFFFE, 1'b1, 1);
    add_vec(OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h80000000, 1'b0, 3);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'hC0000000, 1'b1, 1);
    add_vec(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'h0, 32'hFFFFFFFF, 1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'hFFFFFFF9, 1'b1, 1);
    add_vec(4'd12,    32'h1,        32'h2,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1);
    add_vec(OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h0, 32'h19999999, 1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'd5,        1'b1, 1);
    add_vec(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 1'b0, 34);
    add_vec(OP_MFHI,  32'h0,        32'h0,        32'h0, 32'd1,        1'b1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].alu, 8'(i + 1), 1'b1);
      wait_out(60, lat);
      check($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d_wen", i), 64'(out_wen), 64'(vecs[i].exp_wen));
      check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i + 1));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      @(posedge clk); #1;
    end

    // Eight back-to-back single-cycle ops, including the 9..15 ALU aliases
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send((i % 2 == 0) ? OP_ALU : 4'(9 + i), $urandom, $urandom, $urandom, 8'(8'h40 + i), 1'b1);
    end
    repeat (2) @(negedge clk);
    check("b2b_count", 64'(out_cyc_q.size()), 64'd8);
    for (int i = 1; i < out_cyc_q.size(); i++) begin
      check($sformatf("b2b_gap%0d", i), 64'(out_cyc_q[i] - out_cyc_q[i-1]), 64'd1);
    end
    @(posedge clk); #1;

    // Output held stable while downstream stalls for 5 cycles
    ready_mode = 1;
    hold_val = $urandom;
    send(OP_ALU, 32'h0, 32'h0, hold_val, 8'h77, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_result", i), 64'(out_result), 64'(hold_val));
      check($sformatf("hold%0d_tag", i), 64'(out_tag), 64'h77);
      check($sformatf("hold%0d_wen", i), 64'(out_wen), 64'd1);
      check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    ready_mode = 0;
    drain();

    // Flush in DIV cycle 15: no result, HI/LO untouched
    send(OP_DIVU, 32'd100, 32'd7, 32'h0, 8'h55, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    send(OP_MFHI, 32'h0, 32'h0, 32'h0, 8'h56, 1'b1);
    send(OP_MFLO, 32'h0, 32'h0, 32'h0, 8'h57, 1'b1);
    drain();

    // Reset asserted in DIV cycle 10
    send(OP_DIVU, 32'd1000, 32'd3, 32'h0, 8'h66, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_result", 64'(out_result), 64'd0);
    check("mid_rst_out_wen", 64'(out_wen), 64'd0);
    check("mid_rst_out_tag", 64'(out_tag), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(OP_MFHI, 32'h0, 32'h0, 32'h0, 8'h67, 1'b1);
    send(OP_MFLO, 32'h0, 32'h0, 32'h0, 8'h68, 1'b1);
    drain();

    // Randomized ops with random downstream back-pressure
    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rop = OP_ALU;
      else if (r == 1) rop = 4'($urandom_range(9, 15));
      else             rop = 4'(r - 1);
      send(rop, pick_operand(), pick_operand(), $urandom, 8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
